// File: rtl/fir_tap_sequencer_if.sv
// Host-to-sequencer coefficient stream: valid/ready handshake carrying one
// filter coefficient per accepted transfer.
interface fir_tap_sequencer_if #(
    parameter int TW = 12
);
    logic                 i_coef_valid;
    logic signed [TW-1:0] i_coef;
    logic                 o_coef_ready;

    modport master (
        output i_coef_valid,
        output i_coef,
        input  o_coef_ready
    );

    modport slave (
        input  i_coef_valid,
        input  i_coef,
        output o_coef_ready
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Reloads the FIR coefficient chain from a host stream, then flushes the
// sample delay line with NTAPS zeros so no output mixes old data with new taps.
module fir_tap_sequencer #(
    parameter  int NTAPS = 128,
    parameter  int IW    = 12,
    parameter  int TW    = 12,
    localparam int CW    = $clog2(NTAPS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    fir_tap_sequencer_if.slave   coef_if,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_sample,
    output logic                 o_tap_wr,
    output logic signed [TW-1:0] o_tap,
    output logic                 o_ce,
    output logic signed [IW-1:0] o_sample,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_drop
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    localparam logic [CW-1:0] LAST = CW'(NTAPS - 1);

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  tap_wr_q;
    logic signed [TW-1:0]  tap_q;
    logic                  ce_q;
    logic signed [IW-1:0]  sample_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  drop_q;
    logic                  accept;

    // A restart request wins over a coefficient offered in the same cycle.
    assign coef_if.o_coef_ready = (state_q == LOAD) && !i_start;
    assign accept               = coef_if.i_coef_valid && coef_if.o_coef_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tap_wr_q <= 1'b0;
            tap_q    <= '0;
            ce_q     <= 1'b0;
            sample_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            tap_wr_q <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            ce_q     <= 1'b0;
            sample_q <= '0;
            case (state_q)
                IDLE: begin
                    ce_q     <= i_ce;
                    sample_q <= i_sample;
                    if (i_start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    drop_q <= i_ce;
                    if (i_start) begin
                        cnt_q <= '0;
                    end else if (accept) begin
                        tap_wr_q <= 1'b1;
                        tap_q    <= coef_if.i_coef;
                        if (cnt_q == LAST) begin
                            // First flush cycle coincides with the last tap write.
                            state_q <= FLUSH;
                            cnt_q   <= '0;
                            ce_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    drop_q <= i_ce;
                    if (i_start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        ce_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tap_wr = tap_wr_q;
    assign o_tap    = tap_q;
    assign o_ce     = ce_q;
    assign o_sample = sample_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_drop   = drop_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with NTAPS=4: reset, reload, stalls,
// drops, restart and mid-flush reset.
module tb_fir_tap_sequencer;

    localparam int NTAPS = 4;
    localparam int IW    = 12;
    localparam int TW    = 12;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic          ce     = 1'b0;
    logic [IW-1:0] sample = '0;
    logic          tap_wr;
    logic [TW-1:0] tap;
    logic          oce;
    logic [IW-1:0] osample;
    logic          busy;
    logic          done;
    logic          drop;

    fir_tap_sequencer_if #(.TW(TW)) coef_if ();

    fir_tap_sequencer #(.NTAPS(NTAPS), .IW(IW), .TW(TW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_start   (start),
        .coef_if   (coef_if),
        .i_ce      (ce),
        .i_sample  (sample),
        .o_tap_wr  (tap_wr),
        .o_tap     (tap),
        .o_ce      (oce),
        .o_sample  (osample),
        .o_busy    (busy),
        .o_done    (done),
        .o_drop    (drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int cyc      = 0;
    int wr_cnt   = 0;
    int ce_cnt   = 0;
    int drop_cnt = 0;
    int done_cnt = 0;
    int nzs_cnt  = 0;
    int done_at  = 0;
    logic [TW-1:0] tap_log [64];

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (tap_wr) begin
            tap_log[wr_cnt[5:0]] <= tap;
            wr_cnt <= wr_cnt + 1;
        end
        if (oce) ce_cnt <= ce_cnt + 1;
        if (drop) drop_cnt <= drop_cnt + 1;
        if (oce && osample != '0) nzs_cnt <= nzs_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_at  <= cyc + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_coef(input logic [TW-1:0] c);
        coef_if.i_coef_valid = 1'b1;
        coef_if.i_coef       = c;
        #1;
        chk("coef_ready", 32'(coef_if.o_coef_ready), 32'h1);
        tick();
        coef_if.i_coef_valid = 1'b0;
        chk("tap_wr", 32'(tap_wr), 32'h1);
        chk("tap", 32'(tap), 32'(c));
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'h1);
    endtask

    int s_cyc, s_wr, s_ce, s_drop, s_done, s_nzs;

    task automatic snap();
        s_cyc  = cyc;
        s_wr   = wr_cnt;
        s_ce   = ce_cnt;
        s_drop = drop_cnt;
        s_done = done_cnt;
        s_nzs  = nzs_cnt;
    endtask

    initial begin
        coef_if.i_coef_valid = 1'b0;
        coef_if.i_coef       = '0;

        // Reset held with active inputs.
        rst_n = 1'b0;
        start = 1'b1;
        ce    = 1'b1;
        sample = 12'h7FF;
        coef_if.i_coef_valid = 1'b1;
        coef_if.i_coef       = 12'h555;
        tick();
        tick();
        chk("rst_ready", 32'(coef_if.o_coef_ready), 32'h0);
        chk("rst_tap_wr", 32'(tap_wr), 32'h0);
        chk("rst_tap", 32'(tap), 32'h0);
        chk("rst_ce", 32'(oce), 32'h0);
        chk("rst_sample", 32'(osample), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_drop", 32'(drop), 32'h0);

        rst_n  = 1'b1;
        start  = 1'b0;
        coef_if.i_coef_valid = 1'b0;
        sample = 12'h123;
        tick();
        chk("pass_ce", 32'(oce), 32'h1);
        chk("pass_sample", 32'(osample), 32'h123);
        chk("pass_busy", 32'(busy), 32'h0);
        ce = 1'b0;
        tick();
        chk("pass_ce_off", 32'(oce), 32'h0);

        // Full reload, back-to-back coefficients.
        #1;
        chk("idle_ready", 32'(coef_if.o_coef_ready), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        snap();
        chk("load_busy", 32'(busy), 32'h1);
        send_coef(12'h001);
        send_coef(12'h002);
        send_coef(12'h003);
        send_coef(12'h004);
        chk("flush1_ce", 32'(oce), 32'h1);
        chk("flush1_sample", 32'(osample), 32'h0);
        wait_done(20);
        chk("full_busy_at_done", 32'(busy), 32'h0);
        tick();
        chk("full_done_latency", 32'(done_at - s_cyc), 32'd9);
        chk("full_wr_count", 32'(wr_cnt - s_wr), 32'd4);
        chk("full_ce_count", 32'(ce_cnt - s_ce), 32'd4);
        chk("full_done_count", 32'(done_cnt - s_done), 32'd1);
        chk("full_tap_order0", 32'(tap_log[s_wr]), 32'h001);
        chk("full_tap_order3", 32'(tap_log[s_wr + 3]), 32'h004);
        chk("tap_hold", 32'(tap), 32'h004);

        // Host stalls of 3 cycles between coefficients 2 and 3.
        start = 1'b1;
        tick();
        start = 1'b0;
        snap();
        send_coef(12'h0A1);
        send_coef(12'h0A2);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", 32'(coef_if.o_coef_ready), 32'h1);
            tick();
            chk("stall_no_wr", 32'(tap_wr), 32'h0);
        end
        send_coef(12'h0A3);
        send_coef(12'h0A4);
        wait_done(20);
        tick();
        chk("stall_done_latency", 32'(done_at - s_cyc), 32'd12);
        chk("stall_wr_count", 32'(wr_cnt - s_wr), 32'd4);
        chk("stall_tap_order2", 32'(tap_log[s_wr + 2]), 32'h0A3);

        // Upstream samples held through a reload are dropped.
        start  = 1'b1;
        ce     = 1'b1;
        sample = 12'h3A5;
        tick();
        start = 1'b0;
        snap();
        chk("start_pass_ce", 32'(oce), 32'h1);
        chk("start_pass_sample", 32'(osample), 32'h3A5);
        send_coef(12'h0F1);
        s_nzs = nzs_cnt;
        send_coef(12'h0F2);
        send_coef(12'h0F3);
        send_coef(12'h0F4);
        wait_done(20);
        tick();
        chk("drop_count", 32'(drop_cnt - s_drop), 32'd8);
        chk("drop_no_leak", 32'(nzs_cnt - s_nzs), 32'd0);
        chk("drop_done_latency", 32'(done_at - s_cyc), 32'd9);
        chk("resume_ce", 32'(oce), 32'h1);
        chk("resume_sample", 32'(osample), 32'h3A5);
        ce = 1'b0;
        tick();

        // Restart after two coefficients; coefficient offered with i_start is refused.
        start = 1'b1;
        tick();
        start = 1'b0;
        snap();
        send_coef(12'h101);
        send_coef(12'h102);
        start = 1'b1;
        coef_if.i_coef_valid = 1'b1;
        coef_if.i_coef       = 12'h1FF;
        #1;
        chk("restart_ready", 32'(coef_if.o_coef_ready), 32'h0);
        tick();
        start = 1'b0;
        coef_if.i_coef_valid = 1'b0;
        chk("restart_no_wr", 32'(tap_wr), 32'h0);
        s_cyc = cyc;
        send_coef(12'h201);
        send_coef(12'h202);
        send_coef(12'h203);
        send_coef(12'h204);
        wait_done(20);
        tick();
        chk("restart_wr_count", 32'(wr_cnt - s_wr), 32'd6);
        chk("restart_done_count", 32'(done_cnt - s_done), 32'd1);
        chk("restart_done_latency", 32'(done_at - s_cyc), 32'd9);
        chk("restart_tap_order2", 32'(tap_log[s_wr + 2]), 32'h201);
        chk("restart_tap_order5", 32'(tap_log[s_wr + 5]), 32'h204);

        // Reset in FLUSH cycle 2.
        start = 1'b1;
        tick();
        start = 1'b0;
        send_coef(12'h301);
        send_coef(12'h302);
        send_coef(12'h303);
        send_coef(12'h304);
        tick();
        chk("flush2_ce", 32'(oce), 32'h1);
        snap();
        rst_n = 1'b0;
        #1;
        chk("mrst_tap_wr", 32'(tap_wr), 32'h0);
        chk("mrst_tap", 32'(tap), 32'h0);
        chk("mrst_ce", 32'(oce), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_done", 32'(done), 32'h0);
        tick();
        tick();
        rst_n  = 1'b1;
        ce     = 1'b1;
        sample = 12'h0AB;
        tick();
        chk("mrst_pass_ce", 32'(oce), 32'h1);
        chk("mrst_pass_sample", 32'(osample), 32'h0AB);
        chk("mrst_pass_busy", 32'(busy), 32'h0);
        ce = 1'b0;
        repeat (6) tick();
        chk("mrst_no_done", 32'(done_cnt - s_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Control block that reloads the coefficient chain of the FIR filter at run time and sequences its sample stream around the reload. It accepts NTAPS coefficients from a host over a valid/ready stream and shifts them into the filter's tap-write port. It then flushes the filter's sample delay line with NTAPS zero samples, so no output mixes old data with new taps. It sits between the sample source/host and the filter: all of the filter's tap-write, clock-enable and sample inputs come from this block.

## Interface

- NTAPS, 128, number of filter taps (≥2)
- IW, 12, sample width
- TW, 12, coefficient width
- CW, $clog2(NTAPS+1), internal counter width (derived, not overridden)

- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  request a coefficient reload (pulse)
- i_coef_valid  in  1  host coefficient valid
- i_coef  in  TW  host coefficient
- o_coef_ready  out  1  coefficient accepted when valid && ready
- i_ce  in  1  upstream sample strobe
- i_sample  in  IW  upstream sample
- o_tap_wr  out  1  to filter tap-write strobe
- o_tap  out  TW  to filter tap input
- o_ce  out  1  to filter sample clock-enable
- o_sample  out  IW  to filter sample input
- o_busy  out  1  reload or flush in progress
- o_done  out  1  one-cycle pulse: reload and flush complete
- o_drop  out  1  one-cycle pulse: an upstream sample was discarded

## Operation

- States are IDLE, LOAD and FLUSH. A single counter `cnt` of width CW is shared by LOAD and FLUSH.
- IDLE:
  - Passthrough: o_ce/o_sample are registered copies of i_ce/i_sample.
  - o_tap_wr=0.
  - i_start → LOAD, with cnt=0.
- LOAD:
  - o_coef_ready = (state==LOAD) && !i_start; this is combinational.
  - On accept, the next cycle has o_tap_wr=1 and o_tap=i_coef, and cnt increments.
  - Coefficients are forwarded in arrival order with no reordering; the host supplies them in the filter's chain order.
  - The NTAPS-th accept moves the state to FLUSH with cnt=0.
  - Host stalls (valid=0) are allowed indefinitely. There is no timeout.
- FLUSH:
  - o_ce=1 and o_sample=0 for exactly NTAPS consecutive cycles.
  - After the NTAPS-th cycle the state returns to IDLE and o_done pulses.
- Upstream samples in LOAD or FLUSH: a sample with i_ce=1 is discarded and o_drop pulses the next cycle. In LOAD, o_ce stays 0. In FLUSH, the zero sample is driven instead.
- i_start in LOAD or FLUSH restarts LOAD with cnt=0. Partial taps already written are overwritten by the new sequence.
- i_start in IDLE in the same cycle as an upstream i_ce: that sample is still passed through. o_busy rises the next cycle.
- o_busy = (state != IDLE), registered with the state.
- o_tap holds its last value when o_tap_wr=0. o_sample is zero whenever o_ce=0 in LOAD.

## Timing

- Reset (i_reset_n=0, asynchronous): state=IDLE, cnt=0. All outputs are 0: o_coef_ready, o_tap_wr, o_tap, o_ce, o_sample, o_busy, o_done and o_drop.
- Passthrough latency is 1 cycle, from i_ce/i_sample to o_ce/o_sample.
- Tap latency is 1 cycle, from the accept edge to o_tap_wr.
- i_start sampled at edge t: o_busy=1 and o_coef_ready is eligible from cycle t+1.
- Last coefficient accepted at edge a:
  - o_tap_wr for it is asserted in cycle a+1, which is also the first FLUSH cycle, with o_ce=1.
  - Flush occupies cycles a+1 … a+NTAPS.
  - At cycle a+NTAPS+1: o_done=1, o_busy=0, and passthrough resumes.
- Minimum reload duration with back-to-back valid is 1 + NTAPS + NTAPS cycles from i_start to o_done.
- Reset asserted mid-LOAD or mid-FLUSH aborts immediately with no o_done. The filter keeps whatever partial taps were written.

## Test plan

- Reset (NTAPS=4, IW=TW=12 for all tests): hold i_reset_n=0 while driving i_ce=1, i_start=1 and i_coef_valid=1 → every output is 0. Release, with i_ce=1 and i_sample=0x123 → o_ce=1 and o_sample=0x123 one cycle later.
- Full reload: pulse i_start, then coefficients 0x001, 0x002, 0x003, 0x004 back-to-back →
  - o_tap_wr pulses 4 times with those values, in that order, each 1 cycle after its accept.
  - o_ce=1 with o_sample=0 for 4 cycles.
  - o_done pulses exactly 9 cycles after i_start.
- Host stalls: insert 3 idle cycles between coefficients 2 and 3 → o_coef_ready stays high, no extra o_tap_wr, and o_done is delayed by exactly 3 cycles.
- Drop: hold i_ce=1 through the entire reload → o_drop is asserted every cycle of LOAD and FLUSH, and no upstream sample value appears on o_sample until after o_done.
- Restart: assert i_start after 2 coefficients, then send 4 more → exactly 6 o_tap_wr pulses in total, o_done once, and cnt restarted. A coefficient presented in the same cycle as i_start is not accepted.
- Mid-flush reset: assert i_reset_n=0 in FLUSH cycle 2 → all outputs 0 immediately, o_done never pulses, and the block returns to IDLE passthrough after release.
